// File: rtl/opcode_prefetch_queue.sv
// rtl/opcode_prefetch_queue.sv - byte-wide RAM prefetcher feeding a circular opcode queue
// Presents the head NBYTES bytes as an opcode window; the decoder pops 1..NBYTES bytes per cycle.
module opcode_prefetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDRESS_WIDTH-1:0]       ip,
  input  logic                           flush,
  input  logic [7:0]                     ramData,
  input  logic                           ramBusy,
  output logic                           request,
  output logic [ADDRESS_WIDTH-1:0]       address,
  input  logic                           consume,
  input  logic [$clog2(WORD_WIDTH/8):0]  consumeCount,
  output logic [WORD_WIDTH-1:0]          opcode,
  output logic [ADDRESS_WIDTH-1:0]       opcodeAddress,
  output logic                           valid,
  output logic [$clog2(DEPTH):0]         level
);

  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      pending_q, pending_d;
  logic [7:0]                mem_q [DEPTH];
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [ADDRESS_WIDTH-1:0]  op_addr_q, op_addr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      valid_q, valid_d;

  logic                      push;
  logic                      accept;
  logic [LW-1:0]             pop_cnt;
  logic [LW-1:0]             level_after_push;
  logic [LW-1:0]             level_after_pop;

  // Consume is checked against the pre-update level, so a byte arriving this cycle cannot be popped.
  always_comb begin
    accept = consume && !flush
          && (consumeCount != '0)
          && (LW'(consumeCount) <= LW'(NBYTES))
          && (LW'(consumeCount) <= level_q);
    pop_cnt          = accept ? LW'(consumeCount) : '0;
    level_after_push = level_q + LW'(1) - pop_cnt;
    level_after_pop  = level_q - pop_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // pending_q distinguishes an outstanding read in WAIT from the full-queue hold.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    push      = 1'b0;
    if (flush) begin
      pending_d = 1'b0;
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = (pending_q && ramBusy) ? S_DRAIN : S_REQ;
        default: state_d = ramBusy ? S_DRAIN : S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_REQ: begin
          state_d   = S_WAIT;
          pending_d = 1'b1;
        end
        S_WAIT: begin
          if (pending_q) begin
            if (!ramBusy) begin
              push      = 1'b1;
              pending_d = 1'b0;
              state_d   = (level_after_push < LW'(DEPTH)) ? S_REQ : S_WAIT;
            end
          end else if (level_after_pop < LW'(DEPTH)) begin
            state_d = S_REQ;
          end
        end
        default: begin
          if (!ramBusy) state_d = S_REQ;
        end
      endcase
    end
  end

  always_comb begin
    request = (state_q == S_REQ);
    opcode  = '0;
    for (int k = 0; k < NBYTES; k++) begin
      opcode[WORD_WIDTH-1-8*k -: 8] = mem_q[head_q + PW'(k)];
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    address_d = address_q;
    op_addr_d = op_addr_q;
    level_d   = level_q + LW'(push) - pop_cnt;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      address_d = ip;
      op_addr_d = ip;
      level_d   = '0;
    end else begin
      if (push) begin
        tail_d    = tail_q + PW'(1);
        address_d = address_q + ADDRESS_WIDTH'(1);
      end
      if (accept) begin
        head_d    = head_q + PW'(consumeCount);
        op_addr_d = op_addr_q + ADDRESS_WIDTH'(consumeCount);
      end
    end
    valid_d = (level_d >= LW'(NBYTES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      address_q <= '0;
      op_addr_q <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      address_q <= address_d;
      op_addr_q <= op_addr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      if (push) mem_q[tail_q] <= ramData;
    end
  end

  assign address       = address_q;
  assign opcodeAddress = op_addr_q;
  assign level         = level_q;
  assign valid         = valid_q;

endmodule

// File: tb/tb_opcode_prefetch_queue.sv
// tb/tb_opcode_prefetch_queue.sv - directed self-checking bench for opcode_prefetch_queue
module tb_opcode_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, ramBusy, consume;
  logic [31:0] ip;
  logic [7:0]  ramData;
  logic        request, valid;
  logic [31:0] address, opcodeAddress, opcode;
  logic [2:0]  consumeCount;
  logic [3:0]  level;
  int          errors = 0;
  int          checks = 0;

  opcode_prefetch_queue #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .ip(ip), .flush(flush), .ramData(ramData), .ramBusy(ramBusy),
    .request(request), .address(address), .consume(consume), .consumeCount(consumeCount),
    .opcode(opcode), .opcodeAddress(opcodeAddress), .valid(valid), .level(level)
  );

  always #5 clk = ~clk;

  // RAM returns the low address byte of the read in flight.
  always_comb ramData = address[7:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; ramBusy = 1'b0; consume = 1'b0; consumeCount = 3'd0; ip = 32'h0;
    tick; tick;
    reset = 1'b0;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL rst_request got=%h exp=0", request); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL rst_address got=%h exp=0", address); end
    checks++; if (opcodeAddress !== 32'h0) begin errors++; $display("FAIL rst_opaddr got=%h exp=0", opcodeAddress); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%h exp=0", valid); end
    checks++; if (opcode !== 32'h0) begin errors++; $display("FAIL rst_opcode got=%h exp=0", opcode); end
  endtask

  task automatic test_fill;
    flush = 1'b1; ip = 32'h100;
    tick;
    flush = 1'b0;
    checks++; if (opcodeAddress !== 32'h100) begin errors++; $display("FAIL fill_opaddr0 got=%h exp=100", opcodeAddress); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_level0 got=%0d exp=0", level); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fill_valid_early got=%h exp=0", valid); end
      end
      checks++; if (request !== 1'b1 || address !== 32'h100 + k)
        begin errors++; $display("FAIL fill_req%0d got=%h/%h exp=1/%h", k, request, address, 32'h100 + k); end
      tick;
      checks++; if (request !== 1'b0) begin errors++; $display("FAIL fill_wait%0d got=%h exp=0", k, request); end
      tick;
    end
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL fill_level got=%0d exp=4", level); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%h exp=1", valid); end
    checks++; if (opcode !== 32'h00010203) begin errors++; $display("FAIL fill_opcode got=%h exp=00010203", opcode); end
    checks++; if (opcodeAddress !== 32'h100) begin errors++; $display("FAIL fill_opaddr got=%h exp=100", opcodeAddress); end
  endtask

  task automatic test_full_consume;
    for (int k = 4; k < 8; k++) begin
      checks++; if (request !== 1'b1 || address !== 32'h100 + k)
        begin errors++; $display("FAIL full_req%0d got=%h/%h exp=1/%h", k, request, address, 32'h100 + k); end
      tick; tick;
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level got=%0d exp=8", level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (request !== 1'b0) begin errors++; $display("FAIL full_noreq%0d got=%h exp=0", i, request); end
      tick;
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_hold got=%0d exp=8", level); end
    consume = 1'b1; consumeCount = 3'd3;
    tick;
    consume = 1'b0;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL cons_level got=%0d exp=5", level); end
    checks++; if (opcode !== 32'h03040506) begin errors++; $display("FAIL cons_opcode got=%h exp=03040506", opcode); end
    checks++; if (opcodeAddress !== 32'h103) begin errors++; $display("FAIL cons_opaddr got=%h exp=103", opcodeAddress); end
    checks++; if (request !== 1'b1 || address !== 32'h108)
      begin errors++; $display("FAIL cons_resume got=%h/%h exp=1/108", request, address); end
  endtask

  task automatic test_ram_busy;
    ramBusy = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (request !== 1'b0 || level !== 4'd5)
        begin errors++; $display("FAIL busy_wait%0d got=%h/%0d exp=0/5", i, request, level); end
      tick;
    end
    ramBusy = 1'b0;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL busy_release got=%h exp=0", request); end
    tick;
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL busy_level got=%0d exp=6", level); end
    checks++; if (request !== 1'b1 || address !== 32'h109)
      begin errors++; $display("FAIL busy_next got=%h/%h exp=1/109", request, address); end
    checks++; if (opcode !== 32'h03040506) begin errors++; $display("FAIL busy_opcode got=%h exp=03040506", opcode); end
  endtask

  task automatic test_flush_drain;
    ramBusy = 1'b1;
    tick;
    flush = 1'b1; ip = 32'h200;
    tick;
    flush = 1'b0;
    checks++; if (level !== 4'd0 || valid !== 1'b0)
      begin errors++; $display("FAIL drain_level got=%0d/%h exp=0/0", level, valid); end
    checks++; if (address !== 32'h200 || opcodeAddress !== 32'h200)
      begin errors++; $display("FAIL drain_addr got=%h/%h exp=200/200", address, opcodeAddress); end
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL drain_req got=%h exp=0", request); end
    consume = 1'b1; consumeCount = 3'd1;
    tick;
    consume = 1'b0;
    checks++; if (level !== 4'd0 || opcodeAddress !== 32'h200)
      begin errors++; $display("FAIL drain_overpop got=%0d/%h exp=0/200", level, opcodeAddress); end
    ramBusy = 1'b0;
    tick;
    checks++; if (request !== 1'b1 || address !== 32'h200 || level !== 4'd0)
      begin errors++; $display("FAIL drain_restart got=%h/%h/%0d exp=1/200/0", request, address, level); end
    tick; tick;
    checks++; if (level !== 4'd1 || address !== 32'h201 || request !== 1'b1)
      begin errors++; $display("FAIL drain_first got=%0d/%h/%h exp=1/201/1", level, address, request); end
  endtask

  task automatic test_back_to_back;
    tick;
    flush = 1'b1; ip = 32'h300;
    tick;
    flush = 1'b0;
    checks++; if (level !== 4'd0 || request !== 1'b1 || address !== 32'h300)
      begin errors++; $display("FAIL b2b_flush got=%0d/%h/%h exp=0/1/300", level, request, address); end
    repeat (15) tick;
    checks++; if (level !== 4'd7 || request !== 1'b0)
      begin errors++; $display("FAIL b2b_level7 got=%0d/%h exp=7/0", level, request); end
    consume = 1'b1; consumeCount = 3'd2;
    tick;
    consume = 1'b0;
    checks++; if (level !== 4'd6 || valid !== 1'b1)
      begin errors++; $display("FAIL b2b_pushpop2 got=%0d/%h exp=6/1", level, valid); end
    checks++; if (opcodeAddress !== 32'h302 || opcode !== 32'h02030405)
      begin errors++; $display("FAIL b2b_head2 got=%h/%h exp=302/02030405", opcodeAddress, opcode); end
    checks++; if (request !== 1'b1 || address !== 32'h308)
      begin errors++; $display("FAIL b2b_req308 got=%h/%h exp=1/308", request, address); end
    tick; tick;
    checks++; if (level !== 4'd7 || request !== 1'b1 || address !== 32'h309)
      begin errors++; $display("FAIL b2b_wrap got=%0d/%h/%h exp=7/1/309", level, request, address); end
    tick;
    consume = 1'b1; consumeCount = 3'd1;
    tick;
    checks++; if (level !== 4'd7 || request !== 1'b1 || address !== 32'h30a)
      begin errors++; $display("FAIL b2b_pushpop1 got=%0d/%h/%h exp=7/1/30a", level, request, address); end
    checks++; if (opcodeAddress !== 32'h303 || opcode !== 32'h03040506)
      begin errors++; $display("FAIL b2b_head3 got=%h/%h exp=303/03040506", opcodeAddress, opcode); end
    consumeCount = 3'd5;
    tick;
    checks++; if (level !== 4'd7 || opcodeAddress !== 32'h303)
      begin errors++; $display("FAIL b2b_cc5 got=%0d/%h exp=7/303", level, opcodeAddress); end
    consumeCount = 3'd0;
    tick;
    consume = 1'b0;
    checks++; if (level !== 4'd8 || opcodeAddress !== 32'h303 || request !== 1'b0)
      begin errors++; $display("FAIL b2b_cc0 got=%0d/%h/%h exp=8/303/0", level, opcodeAddress, request); end
  endtask

  task automatic test_reset_mid_wait;
    consume = 1'b1; consumeCount = 3'd4;
    tick;
    consume = 1'b0;
    checks++; if (level !== 4'd4 || request !== 1'b1 || opcodeAddress !== 32'h307)
      begin errors++; $display("FAIL rmw_pre got=%0d/%h/%h exp=4/1/307", level, request, opcodeAddress); end
    ramBusy = 1'b1;
    tick;
    reset = 1'b1; flush = 1'b1; ip = 32'h400;
    tick;
    reset = 1'b0; flush = 1'b0; ramBusy = 1'b0;
    checks++; if (request !== 1'b0 || address !== 32'h0 || opcodeAddress !== 32'h0)
      begin errors++; $display("FAIL rmw_addr got=%h/%h/%h exp=0/0/0", request, address, opcodeAddress); end
    checks++; if (level !== 4'd0 || valid !== 1'b0 || opcode !== 32'h0)
      begin errors++; $display("FAIL rmw_state got=%0d/%h/%h exp=0/0/0", level, valid, opcode); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (request !== 1'b0 || level !== 4'd0)
        begin errors++; $display("FAIL rmw_idle%0d got=%h/%0d exp=0/0", i, request, level); end
    end
    flush = 1'b1; ip = 32'h500;
    tick;
    flush = 1'b0;
    checks++; if (request !== 1'b1 || address !== 32'h500)
      begin errors++; $display("FAIL rmw_restart got=%h/%h exp=1/500", request, address); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_full_consume;
    test_ram_busy;
    test_flush_drain;
    test_back_to_back;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
